// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory controller between instruction fetch and data memory
// One transaction in flight at a time; request fields are captured at grant, and a watchdog ends stalled waits.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              IF_req,
    input  logic [ADDR_W-1:0] IF_addr,
    output logic [DATA_W-1:0] IF_data,
    output logic              IF_done,
    input  logic              DM_req,
    input  logic              DM_write,
    input  logic [ADDR_W-1:0] DM_addr,
    input  logic [DATA_W-1:0] DM_wdata,
    output logic [DATA_W-1:0] DM_rdata,
    output logic              DM_done,
    output logic              O_err,
    output logic              O_busy,
    input  logic              MC_ready,
    input  logic [DATA_W-1:0] MC_data_in,
    input  logic              MC_data_ready,
    output logic              MC_exec,
    output logic              MC_write,
    output logic [ADDR_W-1:0] MC_addr,
    output logic [DATA_W-1:0] MC_data_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    state_t        state;
    logic          gnt_if;
    logic [CW-1:0] cnt;
    logic          if_elig, dm_elig, pick_if, complete, timeout_hit;
    // A port whose done is still visible is skipped so its held request is not re-granted.
    assign if_elig     = IF_req && !IF_done;
    assign dm_elig     = DM_req && !DM_done;
    assign pick_if     = if_elig && (!dm_elig || !gnt_if);
    assign complete    = state == WAIT_RD ? MC_data_ready : MC_ready;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign O_busy      = state != IDLE;
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= IDLE;
            gnt_if      <= 1'b1;
            cnt         <= '0;
            IF_data     <= '0;
            IF_done     <= 1'b0;
            DM_rdata    <= '0;
            DM_done     <= 1'b0;
            O_err       <= 1'b0;
            MC_exec     <= 1'b0;
            MC_write    <= 1'b0;
            MC_addr     <= '0;
            MC_data_out <= '0;
        end else begin
            MC_exec <= 1'b0;
            IF_done <= 1'b0;
            DM_done <= 1'b0;
            O_err   <= 1'b0;
            case (state)
                IDLE: if ((if_elig || dm_elig) && MC_ready) begin
                    gnt_if      <= pick_if;
                    MC_addr     <= pick_if ? IF_addr : DM_addr;
                    MC_write    <= !pick_if && DM_write;
                    MC_data_out <= pick_if ? MC_data_out : DM_wdata;
                    MC_exec     <= 1'b1;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= MC_write ? WAIT_WR : WAIT_RD;
                end
                WAIT_RD, WAIT_WR: if (complete) begin
                    if (state == WAIT_RD && gnt_if) IF_data <= MC_data_in;
                    if (state == WAIT_RD && !gnt_if) DM_rdata <= MC_data_in;
                    IF_done <= gnt_if;
                    DM_done <= !gnt_if;
                    state   <= IDLE;
                end else if (timeout_hit) begin
                    IF_done <= gnt_if;
                    DM_done <= !gnt_if;
                    O_err   <= 1'b1;
                    state   <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant order, capture, completion, watchdog and reset behaviour
module tb_mem_arbiter;
    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        IF_req = 1'b0, DM_req = 1'b0, DM_write = 1'b0;
    logic [15:0] IF_addr = '0, DM_addr = '0, DM_wdata = '0;
    logic [15:0] IF_data, DM_rdata, MC_addr, MC_data_out;
    logic        IF_done, DM_done, O_err, O_busy, MC_exec, MC_write;
    logic        MC_ready = 1'b1, MC_data_ready = 1'b0;
    logic [15:0] MC_data_in = '0;
    int          n_cmp = 0, n_bad = 0, exec_cnt = 0, both_cnt = 0, base = 0, n = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n),
        .IF_req(IF_req), .IF_addr(IF_addr), .IF_data(IF_data), .IF_done(IF_done),
        .DM_req(DM_req), .DM_write(DM_write), .DM_addr(DM_addr), .DM_wdata(DM_wdata),
        .DM_rdata(DM_rdata), .DM_done(DM_done), .O_err(O_err), .O_busy(O_busy),
        .MC_ready(MC_ready), .MC_data_in(MC_data_in), .MC_data_ready(MC_data_ready),
        .MC_exec(MC_exec), .MC_write(MC_write), .MC_addr(MC_addr), .MC_data_out(MC_data_out)
    );

    always #5 I_clk = ~I_clk;

    always @(negedge I_clk) begin
        if (MC_exec) exec_cnt++;
        if (IF_done && DM_done) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge I_clk);
        #1;
    endtask

    task automatic wait_exec(input string tag);
        int k = 0;
        while (MC_exec !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(tag, {31'd0, MC_exec}, 1);
    endtask

    // Controller stand-in: busy from exec, completes lat cycles after the exec cycle.
    task automatic serve(input int lat, input logic wr, input logic [15:0] d);
        MC_ready = 1'b0;
        repeat (lat) tick();
        if (wr) MC_ready = 1'b1;
        else begin
            MC_data_ready = 1'b1;
            MC_data_in    = d;
        end
        check("no_early_done", {30'd0, IF_done, DM_done}, 0);
        tick();
        MC_data_ready = 1'b0;
        MC_ready      = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {26'd0, IF_done, DM_done, O_err, O_busy, MC_exec, MC_write}, 0);
        check({tag, "_mc_addr"}, MC_addr, 0);
        check({tag, "_mc_dout"}, MC_data_out, 0);
        check({tag, "_if_data"}, IF_data, 0);
        check({tag, "_dm_rdata"}, DM_rdata, 0);
    endtask

    task automatic do_reset;
        I_rst_n = 1'b0;
        repeat (2) tick();
        I_rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) tick();
        check_zero("reset");
        I_rst_n = 1'b1;
        tick();

        // 1) single IF read, data two cycles after exec
        base = exec_cnt;
        IF_req = 1'b1; IF_addr = 16'h0010;
        wait_exec("t1_exec");
        check("t1_addr", MC_addr, 16'h0010);
        check("t1_write", {31'd0, MC_write}, 0);
        check("t1_busy", {31'd0, O_busy}, 1);
        serve(2, 1'b0, 16'hBEEF);
        check("t1_done", {30'd0, IF_done, DM_done}, 2'b10);
        check("t1_data", IF_data, 16'hBEEF);
        check("t1_err", {31'd0, O_err}, 0);
        IF_req = 1'b0;
        tick();
        check("t1_done_pulse", {31'd0, IF_done}, 0);
        check("t1_one_exec", exec_cnt - base, 1);
        check("t1_idle", {31'd0, O_busy}, 0);

        // 2) DM store; captured fields must hold after inputs move
        DM_req = 1'b1; DM_write = 1'b1; DM_addr = 16'h0200; DM_wdata = 16'h1234;
        wait_exec("t2_exec");
        check("t2_write", {31'd0, MC_write}, 1);
        check("t2_addr", MC_addr, 16'h0200);
        check("t2_wdata", MC_data_out, 16'h1234);
        serve(3, 1'b1, 16'h0000);
        check("t2_done", {30'd0, IF_done, DM_done}, 2'b01);
        DM_req = 1'b0; DM_write = 1'b0; DM_addr = 16'hFFFF; DM_wdata = 16'h5A5A;
        tick();
        check("t2_hold_addr", MC_addr, 16'h0200);
        check("t2_hold_wdata", MC_data_out, 16'h1234);

        // 3) simultaneous held requests alternate starting with DM
        do_reset();
        base = exec_cnt;
        IF_req = 1'b1; IF_addr = 16'h0100;
        DM_req = 1'b1; DM_write = 1'b0; DM_addr = 16'h0300;
        for (int k = 0; k < 6; k++) begin
            wait_exec($sformatf("t3_exec%0d", k));
            check($sformatf("t3_grant%0d", k), MC_addr, (k % 2 == 0) ? 16'h0300 : 16'h0100);
            serve(1, 1'b0, 16'hA000 + 16'(k));
            check($sformatf("t3_done%0d", k), {30'd0, IF_done, DM_done}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k % 2 == 0) check($sformatf("t3_rdata%0d", k), DM_rdata, 16'hA000 + 16'(k));
            else check($sformatf("t3_idata%0d", k), IF_data, 16'hA000 + 16'(k));
            if (k == 4) DM_req = 1'b0;
            if (k == 5) IF_req = 1'b0;
        end
        repeat (3) tick();
        check("t3_exec_total", exec_cnt - base, 6);

        // 4) IF req held through its done cycle; pending DM wins instead
        base = exec_cnt;
        IF_req = 1'b1; IF_addr = 16'h0040;
        wait_exec("t4_exec_if");
        check("t4_addr_if", MC_addr, 16'h0040);
        DM_req = 1'b1; DM_write = 1'b0; DM_addr = 16'h0500;
        serve(1, 1'b0, 16'h4444);
        check("t4_if_done", {30'd0, IF_done, DM_done}, 2'b10);
        tick();
        IF_req = 1'b0;
        check("t4_exec_dm", {31'd0, MC_exec}, 1);
        check("t4_addr_dm", MC_addr, 16'h0500);
        serve(2, 1'b0, 16'h5555);
        check("t4_dm_done", {30'd0, IF_done, DM_done}, 2'b01);
        check("t4_dm_rdata", DM_rdata, 16'h5555);
        DM_req = 1'b0;
        tick();
        check("t4_exec_total", exec_cnt - base, 2);

        // 5) watchdog: controller never answers
        IF_req = 1'b1; IF_addr = 16'h0077;
        wait_exec("t5_exec");
        MC_ready = 1'b0;
        n = 0;
        while (!IF_done && n < 20) begin
            tick();
            n++;
        end
        check("t5_latency", n, 9);
        check("t5_err", {31'd0, O_err}, 1);
        check("t5_data_kept", IF_data, 16'h4444);
        IF_req = 1'b0;
        DM_req = 1'b1; DM_write = 1'b0; DM_addr = 16'h0600;
        base = exec_cnt;
        tick();
        check("t5_err_pulse", {31'd0, O_err}, 0);
        repeat (4) tick();
        check("t5_no_exec", exec_cnt - base, 0);
        check("t5_idle", {31'd0, O_busy}, 0);
        MC_ready = 1'b1;
        wait_exec("t5_exec_dm");
        check("t5_addr_dm", MC_addr, 16'h0600);
        serve(1, 1'b0, 16'h600D);
        check("t5_dm_rdata", DM_rdata, 16'h600D);
        check("t5_dm_noerr", {31'd0, O_err}, 0);
        DM_req = 1'b0;
        tick();

        // 6) asynchronous reset during WAIT_RD
        IF_req = 1'b1; IF_addr = 16'h0088;
        wait_exec("t6_exec");
        MC_ready = 1'b0;
        repeat (2) tick();
        check("t6_busy_before", {31'd0, O_busy}, 1);
        #2 I_rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        repeat (2) tick();
        I_rst_n = 1'b1;
        base = exec_cnt;
        repeat (4) tick();
        check("t6_no_exec", exec_cnt - base, 0);
        MC_ready = 1'b1;
        wait_exec("t6_exec_after");
        check("t6_addr", MC_addr, 16'h0088);
        serve(1, 1'b0, 16'hCAFE);
        check("t6_done", {30'd0, IF_done, DM_done}, 2'b10);
        check("t6_data", IF_data, 16'hCAFE);
        IF_req = 1'b0;
        tick();

        check("never_both_done", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
